pacman_move_ctrl: RTL
=====================

Name: pacman_move_ctrl

Overview:
- Per-tick Pac-Man movement sequencer. Sits upstream of the map RAM controller and the character-register file.
- On each slow-clock tick it latches the player direction and reads the target tile from the map. It then decides whether to move, updates Pac-Man's tile position, and clears eaten pellets by writing back to the map.
- Its position outputs feed the character registers; its map_* outputs share the map port with the display controller through an external arbiter, which grants the port when busy=1.

Parameters:
- MAP_W, 20, map width in tiles (x range 0..MAP_W-1)
- MAP_H, 15, map height in tiles (y range 0..MAP_H-1)
- PAC_X0, 9, reset x tile
- PAC_Y0, 11, reset y tile
- READ_LAT, 1, cycles from map address to valid map_rdata (1..3)

Ports:
- clock_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle move strobe from the rate divider
- en  in  1  movement enable; when 0, ticks are ignored
- dir_keys  in  4  active-low buttons: [0]=right, [1]=left, [2]=down, [3]=up
- map_rdata  in  3  sprite code read from the map
- map_x  out  5  map tile x address
- map_y  out  5  map tile y address
- map_wdata  out  3  sprite code to write
- map_readwrite  out  1  0=read, 1=write (one-cycle write strobe)
- pacman_x  out  5  current tile x
- pacman_y  out  5  current tile y
- pacman_orientation  out  2  0=right, 1=left, 2=down, 3=up
- score  out  10  pellets eaten, saturating at 1023
- busy  out  1  1 while the FSM is outside IDLE
- moved  out  1  one-cycle pulse when the position changes

Behaviour:
- Reset (asynchronous, active-high): pacman_x=PAC_X0, pacman_y=PAC_Y0, orientation=0, score=0, map_x=0, map_y=0, map_wdata=0, map_readwrite=0, busy=0, moved=0, FSM=IDLE, dir_valid=0. Reset asserted mid-sequence aborts it with no partial write.
- Sprite codes: 0 EMPTY, 1 WALL, 2 PELLET, 3 POWER. Codes 4-7 are treated as EMPTY.
- FSM states: IDLE, ADDR, WAIT, EVAL, WRITE.
- IDLE:
  - A tick with en=1 latches the direction: lowest-index pressed key wins (right>left>down>up).
  - If no key is pressed, the last latched direction is reused.
  - If no key is pressed and dir_valid=0, stay in IDLE.
  - Otherwise set orientation to the latched direction, set dir_valid=1, and go to ADDR.
- ADDR:
  - Compute the target tile from the current position and direction, with wrap-around: x=0 going left gives MAP_W-1; x=MAP_W-1 going right gives 0; y wraps the same way with MAP_H.
  - Drive map_x/map_y with the target and map_readwrite=0. Go to WAIT.
- WAIT: hold the address for READ_LAT cycles, then go to EVAL.
- EVAL: sample map_rdata.
  - WALL: position unchanged, moved=0, go to IDLE.
  - Anything else: pacman_x/y take the target next edge and moved pulses for 1 cycle.
  - PELLET or POWER: go to WRITE. Otherwise go to IDLE.
- WRITE:
  - One cycle with map_readwrite=1, map_wdata=0, address still on the target.
  - score increments by 1, saturating at 1023. Go to IDLE.
- Ticks arriving outside IDLE are dropped (not queued).
- busy=1 in every state except IDLE.
- Worst-case latency from tick to IDLE: 4+READ_LAT cycles.
- en is sampled only in IDLE; deasserting it mid-sequence does not abort.
- map_readwrite is 0 in every state except WRITE.

Decomposition:
- Shared package pacman_pkg holds:
  - sprite-code constants: SPR_EMPTY, SPR_WALL, SPR_PELLET, SPR_POWER
  - direction encodings: DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP
  - FSM state typedef
  - MAP_W/MAP_H defaults
- One sub-module, tile_step: combinational next-tile calculator with wrap-around. Inputs are x, y and dir; outputs are tx, ty. It is reused later by ghost controllers.

Test Plan:
- Reset mid-WAIT → pacman=(9,11), orientation=0, score=0, busy=0, map_readwrite=0 immediately, without waiting for a clock edge.
- Right key, tick, target (10,11)=EMPTY → map_x=10/map_y=11 read; pacman_x=10 after 3+READ_LAT cycles; moved pulse 1 cycle; no write.
- Up key from (9,11), target (9,10)=WALL → position unchanged, orientation=3, moved=0, map_readwrite never 1.
- Left key at x=0, target (19,y)=PELLET → pacman_x=19; one write cycle at (19,y) with wdata=0; score 0→1.
- No key after a prior right move, then tick → repeats right move. No key and no prior direction → stays IDLE, busy=0.
- Second tick during WAIT → ignored. Score preloaded at 1023 via 1023 pellets, then eat another → score stays 1023.

Source files
------------

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared sprite codes, directions and FSM states for Pac-Man movement
package pacman_pkg;

    localparam int MAP_W_DEF = 20;
    localparam int MAP_H_DEF = 15;

    localparam logic [2:0] SPR_EMPTY  = 3'd0;
    localparam logic [2:0] SPR_WALL   = 3'd1;
    localparam logic [2:0] SPR_PELLET = 3'd2;
    localparam logic [2:0] SPR_POWER  = 3'd3;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_EVAL,
        ST_WRITE
    } move_state_t;

    // Lowest-index pressed key wins: right > left > down > up.
    function automatic logic [1:0] pick_dir(input logic [3:0] pressed);
        if (pressed[0]) return DIR_RIGHT;
        else if (pressed[1]) return DIR_LEFT;
        else if (pressed[2]) return DIR_DOWN;
        else return DIR_UP;
    endfunction

endpackage

// File: rtl/tile_step.sv
// rtl/tile_step.sv - combinational one-tile step with wrap-around at the map edges
module tile_step
    import pacman_pkg::*;
#(
    parameter int MAP_W = MAP_W_DEF,
    parameter int MAP_H = MAP_H_DEF
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] tx,
    output logic [4:0] ty
);

    localparam logic [4:0] X_MAX = 5'(MAP_W - 1);
    localparam logic [4:0] Y_MAX = 5'(MAP_H - 1);

    // Step one tile in dir; leaving one edge re-enters at the opposite edge.
    always_comb begin
        tx = x;
        ty = y;
        case (dir)
            DIR_RIGHT: tx = (x == X_MAX) ? 5'd0 : x + 5'd1;
            DIR_LEFT:  tx = (x == 5'd0) ? X_MAX : x - 5'd1;
            DIR_DOWN:  ty = (y == Y_MAX) ? 5'd0 : y + 5'd1;
            DIR_UP:    ty = (y == 5'd0) ? Y_MAX : y - 5'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pacman_move_ctrl.sv
// rtl/pacman_move_ctrl.sv - per-tick Pac-Man move sequencer with map read and pellet clear
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int MAP_W    = MAP_W_DEF,
    parameter int MAP_H    = MAP_H_DEF,
    parameter int PAC_X0   = 9,
    parameter int PAC_Y0   = 11,
    parameter int READ_LAT = 1
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       en,
    input  logic [3:0] dir_keys,
    input  logic [2:0] map_rdata,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    output logic [2:0] map_wdata,
    output logic       map_readwrite,
    output logic [4:0] pacman_x,
    output logic [4:0] pacman_y,
    output logic [1:0] pacman_orientation,
    output logic [9:0] score,
    output logic       busy,
    output logic       moved
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);
    localparam logic [9:0] SCORE_MAX = 10'd1023;

    move_state_t state, state_next;
    logic [1:0]  dir_q;
    logic        dir_valid;
    logic [1:0]  wait_cnt;
    logic [3:0]  pressed;
    logic        key_any;
    logic        start;
    logic [1:0]  dir_sel;
    logic [4:0]  tgt_x, tgt_y;
    logic        tgt_wall, tgt_food;

    assign pressed  = ~dir_keys;
    assign key_any  = |pressed;
    assign dir_sel  = key_any ? pick_dir(pressed) : dir_q;
    assign start    = tick && en && (key_any || dir_valid);
    assign tgt_wall = (map_rdata == SPR_WALL);
    assign tgt_food = (map_rdata == SPR_PELLET) || (map_rdata == SPR_POWER);

    tile_step #(
        .MAP_W(MAP_W),
        .MAP_H(MAP_H)
    ) u_tile_step (
        .x  (pacman_x),
        .y  (pacman_y),
        .dir(dir_q),
        .tx (tgt_x),
        .ty (tgt_y)
    );

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state decode and busy flag.
    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start) state_next = ST_ADDR;
            ST_ADDR:  state_next = ST_WAIT;
            ST_WAIT:  if (wait_cnt == WAIT_LAST) state_next = ST_EVAL;
            ST_EVAL: begin
                if (tgt_wall)      state_next = ST_IDLE;
                else if (tgt_food) state_next = ST_WRITE;
                else               state_next = ST_IDLE;
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: direction latch, map address, position, write strobe and score.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            dir_q              <= DIR_RIGHT;
            dir_valid          <= 1'b0;
            wait_cnt           <= 2'd0;
            map_x              <= 5'd0;
            map_y              <= 5'd0;
            map_wdata          <= SPR_EMPTY;
            map_readwrite      <= 1'b0;
            pacman_x           <= 5'(PAC_X0);
            pacman_y           <= 5'(PAC_Y0);
            pacman_orientation <= DIR_RIGHT;
            score              <= 10'd0;
            moved              <= 1'b0;
        end else begin
            moved         <= 1'b0;
            map_readwrite <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_q              <= dir_sel;
                        pacman_orientation <= dir_sel;
                        dir_valid          <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    map_x    <= tgt_x;
                    map_y    <= tgt_y;
                    wait_cnt <= 2'd0;
                end
                ST_WAIT: wait_cnt <= wait_cnt + 2'd1;
                ST_EVAL: begin
                    if (!tgt_wall) begin
                        pacman_x <= map_x;
                        pacman_y <= map_y;
                        moved    <= 1'b1;
                        if (tgt_food) begin
                            map_readwrite <= 1'b1;
                            map_wdata     <= SPR_EMPTY;
                        end
                    end
                end
                ST_WRITE: begin
                    if (score != SCORE_MAX) score <= score + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
